// File: rtl/cpu_switch_ctrl.sv
`default_nettype none
// ==========================================================================
// cpu_switch_ctrl : dual-CPU heartbeat watchdogs and host-selection FSM.
// Optional macro AUTO_SWI_EN enables automatic failover.  Rev 1.0
// ==========================================================================
module cpu_switch_ctrl #(
   parameter logic [31:0] HB_TIMEOUT = 32'd50000000,
   parameter logic [31:0] HOLDOFF    = 32'd100000000,
   parameter int          CNT_W      = 32
) (
   input  logic clk,
   input  logic rst_n,
   input  logic force_swi,
   input  logic com_swi,
   input  logic reset_a_signal,
   input  logic reset_b_signal,
   input  logic power_on_A,
   input  logic power_on_B,
   input  logic hb_a,
   input  logic hb_b,
   output logic switch,
   output logic alive_a,
   output logic alive_b,
   output logic both_fail,
   output logic swi_event,
   output logic auto_swi
);

   localparam logic [CNT_W-1:0] C_TIMEOUT   = CNT_W'(HB_TIMEOUT);
   localparam logic [CNT_W-1:0] C_HOLD_LAST = CNT_W'(HOLDOFF - 32'd1);
`ifdef AUTO_SWI_EN
   localparam bit C_AUTO_EN = 1'b1;
`else
   localparam bit C_AUTO_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      HOST_A = 2'd0,
      HOST_B = 2'd1,
      HOLD_A = 2'd2,
      HOLD_B = 2'd3
   } state_t;

   logic [1:0] w_hb;
   logic [1:0] w_mask;
   logic [1:0] w_pwr;
   logic [1:0] w_alive;

   assign w_hb   = {hb_b, hb_a};
   assign w_mask = {reset_b_signal, reset_a_signal};
   assign w_pwr  = {power_on_B, power_on_A};

   // Index 0 is CPU A, index 1 is CPU B.
   for (genvar i = 0; i < 2; i++) begin : g_wd
      logic [2:0]       r_sync;
      logic [CNT_W-1:0] r_cnt;
      logic             r_alive;
      logic             w_beat;

      assign w_beat     = r_sync[1] ^ r_sync[2];
      assign w_alive[i] = r_alive;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_alive <= 1'b1;
         end else begin
            r_sync <= {r_sync[1:0], w_hb[i]};
            if (w_mask[i] || w_beat)
               r_cnt <= '0;
            else if (r_cnt != C_TIMEOUT)
               r_cnt <= r_cnt + 1'b1;
            // A beat arriving as the counter saturates keeps the CPU alive.
            r_alive <= w_pwr[i] & (w_beat | (r_cnt != C_TIMEOUT));
         end
      end
   end

   assign alive_a = w_alive[0];
   assign alive_b = w_alive[1];

   state_t           r_state;
   logic [CNT_W-1:0] r_hold;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= HOST_A;
         r_hold    <= '0;
         switch    <= 1'b0;
         swi_event <= 1'b0;
         auto_swi  <= 1'b0;
         both_fail <= 1'b0;
      end else begin
         swi_event <= 1'b0;
         both_fail <= ~w_alive[0] & ~w_alive[1];
         if (force_swi) begin
            r_state   <= com_swi ? HOLD_B : HOLD_A;
            r_hold    <= '0;
            switch    <= com_swi;
            swi_event <= com_swi ^ switch;
            auto_swi  <= 1'b0;
         end else begin
            case (r_state)
               HOST_A: begin
                  if (C_AUTO_EN && !w_alive[0] && w_alive[1]) begin
                     r_state   <= HOLD_B;
                     r_hold    <= '0;
                     switch    <= 1'b1;
                     swi_event <= 1'b1;
                     auto_swi  <= 1'b1;
                  end
               end
               HOST_B: begin
                  if (C_AUTO_EN && !w_alive[1] && w_alive[0]) begin
                     r_state   <= HOLD_A;
                     r_hold    <= '0;
                     switch    <= 1'b0;
                     swi_event <= 1'b1;
                     auto_swi  <= 1'b1;
                  end
               end
               HOLD_A: begin
                  if (r_hold == C_HOLD_LAST) r_state <= HOST_A;
                  else                       r_hold  <= r_hold + 1'b1;
               end
               HOLD_B: begin
                  if (r_hold == C_HOLD_LAST) r_state <= HOST_B;
                  else                       r_hold  <= r_hold + 1'b1;
               end
               default: r_state <= HOST_A;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/cpu_switch_ctrl.md
Name: cpu_switch_ctrl

Overview:
Downstream consumer of the command decoder's force_swi/com_swi outputs and its CPU reset/power controls. Runs one heartbeat watchdog per CPU and owns the host-selection state. Drives the registered switch signal that feeds back into the command decoder (0 = CPU A host, 1 = CPU B host). Fails over automatically when the host CPU stops toggling its heartbeat and the standby is alive.

Parameters:
HB_TIMEOUT, 32'd50000000, cycles without a heartbeat edge before a CPU is declared dead (1 s at 50 MHz)
HOLDOFF, 32'd100000000, cycles after any host change during which automatic switching is inhibited
CNT_W, 32, width of the watchdog and holdoff counters

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
force_swi  input  1  one-cycle forced-switch strobe from the command decoder
com_swi  input  1  forced target, sampled with force_swi: 0 = A, 1 = B
reset_a_signal  input  1  CPU A reset pulse is active (mask A watchdog)
reset_b_signal  input  1  CPU B reset pulse is active (mask B watchdog)
power_on_A  input  1  CPU A powered
power_on_B  input  1  CPU B powered
hb_a  input  1  CPU A heartbeat, asynchronous, toggling
hb_b  input  1  CPU B heartbeat, asynchronous, toggling
switch  output  1  current host: 0 = A, 1 = B
alive_a  output  1  CPU A watchdog healthy
alive_b  output  1  CPU B watchdog healthy
both_fail  output  1  both CPUs dead
swi_event  output  1  one-cycle pulse on every host change
auto_swi  output  1  sticky flag, set by an automatic failover, cleared by force_swi

Behaviour:
- Reset: clk and rst_n; rst_n is asynchronous and active-low. On reset: switch=0, alive_a=alive_b=1, both_fail=0, swi_event=0, auto_swi=0, counters=0, state=HOST_A.
- Heartbeat input path:
  - hb_x passes through a 2-flop synchroniser, then a third register for edge detect.
  - Any edge (either polarity) is a beat.
  - Beat detection latency is 3 cycles from the pin.
- Watchdog counter per CPU, width CNT_W:
  - Cleared on a beat.
  - Held at 0 while reset_x_signal=1.
  - Otherwise increments, saturating at HB_TIMEOUT.
  - alive_x is registered: 0 when the counter equals HB_TIMEOUT or power_on_x=0, else 1.
  - A beat restores alive_x=1 on the next cycle.
- both_fail is registered: ~alive_a & ~alive_b.
- States:
  - HOST_A, HOST_B: steady.
  - HOLD_A, HOLD_B: holdoff after a change, host unchanged.
  - switch = 1 in HOST_B/HOLD_B, else 0.
- Holdoff counter:
  - Loaded to 0 on entry to HOLD_x.
  - Increments each cycle.
  - HOLD_x goes to HOST_x when the counter reaches HOLDOFF-1.
- Transitions, in priority order:
  1. force_swi=1: go to HOLD_A if com_swi=0, else HOLD_B. Honoured in every state, including holdoff. Clears auto_swi.
     - Forcing to the current host: state goes to HOLD_x (holdoff restarts) but swi_event is not pulsed.
  2. HOST_A with ~alive_a & alive_b: go to HOLD_B, set auto_swi. HOST_B with ~alive_b & alive_a: mirrored.
  3. Both dead: remain on the current host; both_fail=1.
- swi_event pulses for exactly 1 cycle, registered, in the cycle switch changes.
- Latency:
  - force_swi to switch change: 1 cycle.
  - Watchdog expiry to switch change: 2 cycles (alive register, then state).
- Simultaneous events:
  - force_swi in the same cycle as an auto condition: force wins and auto_swi stays 0.
  - Beat in the cycle the counter would saturate: counter clears and alive stays 1.
- Power-off of the host CPU drops alive immediately, so failover follows if the standby is alive and no holdoff is active.
- rst_n asserted mid-holdoff or mid-timeout: everything returns to reset values.

Optional Feature:
AUTO_SWI_EN
- Defined: automatic failover (transition priority 2) is enabled as described above.
- Undefined: watchdogs, alive_x and both_fail still operate. switch changes only on force_swi, auto_swi is tied to 0, and the holdoff states still exist for forced changes.

Test Plan:
Bench parameters: HB_TIMEOUT=16, HOLDOFF=8, AUTO_SWI_EN defined.
- Reset release with both heartbeats toggling every 4 cycles -> switch=0, alive_a=alive_b=1, swi_event never pulses.
- Stop hb_a, keep hb_b toggling -> alive_a=0 about 19 cycles after the last A edge. switch=1 and swi_event pulses 1 cycle later; auto_swi=1.
- force_swi with com_swi=0 issued 3 cycles into HOLD_B -> switch=0 next cycle, swi_event pulse, auto_swi=0, holdoff restarts for 8 cycles.
- Host A dies during HOLD_A -> no switch until the holdoff ends, then switch=1 at holdoff cycle 8.
- Stop both heartbeats -> both_fail=1, switch unchanged. Resume hb_b only -> both_fail=0 and auto switch to B if A is host.
- Hold reset_a_signal=1 for 40 cycles with hb_a quiet -> alive_a stays 1 and no switch. Set power_on_A=0 -> alive_a=0 next cycle and failover.
